mem_arbiter_n: RTL and testbench

Parametrised N-channel arbiter between the L1 caches and the shared next-level memory port (L2 or shadow memory). It accepts line-granular read/write requests from NUM_PORTS requesters and serialises them onto one downstream port, one transaction at a time. Downstream command signals and upstream responses are registered. Grant selection is round-robin or fixed-priority, chosen at compile time.

---
 rtl/mem_arbiter_n.sv | 79 +++++++
 tb/tb_mem_arbiter_n.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: serialises NUM_PORTS line-granular read/write channels onto one downstream memory port
// Ports: clk, rst (sync, active-high); ch_read/ch_write/ch_addr/ch_wdata per-channel requests (packed),
//        ch_rdata/ch_resp registered responses; mem_read/mem_write/mem_addr/mem_wdata registered
//        downstream command, mem_rdata/mem_resp downstream completion.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin grant; undefined gives fixed lowest-index priority.
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 27,
  parameter int LINE_W    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        ch_read,
  input  logic [NUM_PORTS-1:0]        ch_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] ch_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]           ch_rdata,
  output logic [NUM_PORTS-1:0]        ch_resp,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp
);
  localparam int GW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;
  state_t               state;
  logic [GW-1:0]        last_g;
  logic [GW-1:0]        sel;
  logic [NUM_PORTS-1:0] req;
  assign req = ch_read | ch_write;
  // last_g doubles as the grant of the transaction in flight, since it only moves on a grant.
  always_comb begin
    sel = '0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = NUM_PORTS; i >= 1; i--)
      if (req[(int'(last_g) + i) % NUM_PORTS]) sel = GW'((int'(last_g) + i) % NUM_PORTS);
`else
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (req[i]) sel = GW'(i);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_resp   <= '0;
      ch_rdata  <= '0;
      last_g    <= GW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: if (|req) begin
          last_g    <= sel;
          mem_addr  <= ch_addr[sel*ADDR_W +: ADDR_W];
          mem_wdata <= ch_wdata[sel*LINE_W +: LINE_W];
          mem_write <= ch_write[sel];
          mem_read  <= ch_read[sel] & ~ch_write[sel];
          state     <= ACTIVE;
        end
        ACTIVE: if (mem_resp) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ch_resp   <= NUM_PORTS'(1) << last_g;
          ch_rdata  <= mem_rdata;
          state     <= RECOVER;
        end
        RECOVER: begin
          ch_resp <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed table-driven bench for mem_arbiter_n (2-port and 4-port instances)
module tb_mem_arbiter_n;
  localparam logic [26:0] A0 = 27'h0123456;
  localparam logic [26:0] A1 = 27'h0ABCDEF;
  localparam logic [26:0] Z  = 27'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]   rd2, wr2, resp2_o;
  logic [53:0]  addr2;
  logic [511:0] wdata2;
  logic [255:0] rdata2_o, mwd2, mrd2;
  logic         mr2, mw2, mresp2;
  logic [26:0]  ma2;
  mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(27), .LINE_W(256)) u2 (
    .clk(clk), .rst(rst), .ch_read(rd2), .ch_write(wr2), .ch_addr(addr2), .ch_wdata(wdata2),
    .ch_rdata(rdata2_o), .ch_resp(resp2_o), .mem_read(mr2), .mem_write(mw2), .mem_addr(ma2),
    .mem_wdata(mwd2), .mem_rdata(mrd2), .mem_resp(mresp2));
  logic [3:0]    rd4, wr4, resp4_o;
  logic [107:0]  addr4;
  logic [1023:0] wdata4;
  logic [255:0]  rdata4_o, mwd4, mrd4;
  logic          mr4, mw4, mresp4;
  logic [26:0]   ma4;
  mem_arbiter_n #(.NUM_PORTS(4), .ADDR_W(27), .LINE_W(256)) u4 (
    .clk(clk), .rst(rst), .ch_read(rd4), .ch_write(wr4), .ch_addr(addr4), .ch_wdata(wdata4),
    .ch_rdata(rdata4_o), .ch_resp(resp4_o), .mem_read(mr4), .mem_write(mw4), .mem_addr(ma4),
    .mem_wdata(mwd4), .mem_rdata(mrd4), .mem_resp(mresp4));
  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input int idx, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [1:0]  rd, wr;
    logic        resp;
    logic [31:0] rdat;
    logic        mr, mw;
    logic [1:0]  er;
    logic [26:0] ea;
    logic [31:0] erd, ewd;
  } vec_t;
  vec_t v[23];
  int exp_g;
  logic [3:0] req;
  initial begin
    v[0]  = '{2'b00, 2'b00, 1'b1, 32'h11111111, 1'b0, 1'b0, 2'b00, Z,  32'h0,        32'h0};
    v[1]  = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h0,        32'hCAFEF00D};
    v[2]  = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h0,        32'hCAFEF00D};
    v[3]  = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h0,        32'hCAFEF00D};
    v[4]  = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h0,        32'hCAFEF00D};
    v[5]  = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h0,        32'hCAFEF00D};
    v[6]  = '{2'b10, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b10, A1, 32'hDEADBEEF, 32'hCAFEF00D};
    v[7]  = '{2'b00, 2'b00, 1'b0, 32'h22222222, 1'b0, 1'b0, 2'b00, A1, 32'hDEADBEEF, 32'hCAFEF00D};
    v[8]  = '{2'b00, 2'b01, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, A0, 32'hDEADBEEF, 32'h12345678};
    v[9]  = '{2'b00, 2'b01, 1'b1, 32'h33333333, 1'b0, 1'b0, 2'b01, A0, 32'h33333333, 32'h12345678};
    v[10] = '{2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, A0, 32'h33333333, 32'h12345678};
    v[11] = '{2'b01, 2'b01, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, A0, 32'h33333333, 32'h12345678};
    v[12] = '{2'b01, 2'b01, 1'b1, 32'h44444444, 1'b0, 1'b0, 2'b01, A0, 32'h44444444, 32'h12345678};
    v[13] = '{2'b10, 2'b00, 1'b1, 32'h55555555, 1'b0, 1'b0, 2'b00, A0, 32'h44444444, 32'h12345678};
    v[14] = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h44444444, 32'hCAFEF00D};
    v[15] = '{2'b10, 2'b00, 1'b1, 32'h66666666, 1'b0, 1'b0, 2'b10, A1, 32'h66666666, 32'hCAFEF00D};
    v[16] = '{2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, A1, 32'h66666666, 32'hCAFEF00D};
    v[17] = '{2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A0, 32'h66666666, 32'h12345678};
    v[18] = '{2'b11, 2'b00, 1'b1, 32'h77777777, 1'b0, 1'b0, 2'b01, A0, 32'h77777777, 32'h12345678};
    v[19] = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, A0, 32'h77777777, 32'h12345678};
    v[20] = '{2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, A1, 32'h77777777, 32'hCAFEF00D};
    v[21] = '{2'b10, 2'b00, 1'b1, 32'h88888888, 1'b0, 1'b0, 2'b10, A1, 32'h88888888, 32'hCAFEF00D};
    v[22] = '{2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, A1, 32'h88888888, 32'hCAFEF00D};
    rd2 = '0; wr2 = '0; mresp2 = 1'b0; mrd2 = '0;
    addr2  = {A1, A0};
    wdata2 = {{8{32'hCAFEF00D}}, {8{32'h12345678}}};
    rd4 = '0; wr4 = '0; mresp4 = 1'b0; mrd4 = '0; wdata4 = '0;
    for (int i = 0; i < 4; i++) addr4[i*27 +: 27] = 27'(32'h100 + i);
    tick;
    tick;
    chk("reset2", 0, 264'({mr2, mw2, resp2_o, ma2, mwd2}), 264'(0));
    chk("reset2_rdata", 0, 264'(rdata2_o), 264'(0));
    chk("reset4", 0, 264'({mr4, mw4, resp4_o, ma4, rdata4_o}), 264'(0));
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      rd2 = v[i].rd; wr2 = v[i].wr; mresp2 = v[i].resp; mrd2 = {8{v[i].rdat}};
      tick;
      chk("ctl", i, 264'({mr2, mw2, resp2_o, ma2}), 264'({v[i].mr, v[i].mw, v[i].er, v[i].ea}));
      chk("ch_rdata", i, 264'(rdata2_o), 264'({8{v[i].erd}}));
      chk("mem_wdata", i, 264'(mwd2), 264'({8{v[i].ewd}}));
    end
    rd2 = 2'b01; wr2 = 2'b00; mresp2 = 1'b0;
    tick;
    chk("rst_pre", 0, 264'({mr2, mw2, ma2}), 264'({1'b1, 1'b0, A0}));
    rst = 1'b1; rd2 = 2'b00;
    tick;
    chk("rst_mid", 0, 264'({mr2, mw2, resp2_o, ma2}), 264'(0));
    rst = 1'b0; mresp2 = 1'b1; mrd2 = {8{32'h99999999}};
    tick;
    chk("rst_stray", 0, 264'({mr2, mw2, resp2_o, rdata2_o}), 264'(0));
    mresp2 = 1'b0;
    tick;
    chk("rst_after", 0, 264'({mr2, resp2_o}), 264'(0));
    req = 4'hF;
    rd4 = req;
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = k % 4;
`else
      exp_g = 0;
`endif
      tick;
      chk("grant4", k, 264'({mr4, mw4, ma4}), 264'({1'b1, 1'b0, 27'(32'h100 + exp_g)}));
      mresp4 = 1'b1;
      tick;
      chk("resp4", k, 264'({mr4, resp4_o}), 264'({1'b0, 4'(4'b1 << exp_g)}));
      mresp4 = 1'b0;
      req[exp_g] = 1'b0;
      rd4 = req;
      tick;
      chk("resp4_off", k, 264'({mr4, resp4_o}), 264'(0));
      req = 4'hF;
      rd4 = req;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
